// File: rtl/sprite_palette_bank.sv
// Banked, runtime-writable sprite palette with a two-stage registered lookup.
// Optional colour flash is compiled in with `define PALETTE_FLASH_EN.
module sprite_palette_bank #(
    parameter int INDEX_W         = 4,
    parameter int BANKS           = 4,
    parameter int BANK_W          = 2,
    parameter int COLOR_W         = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter int FLASH_LEN       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pix_valid,
    input  logic [BANK_W-1:0]    bank_sel,
    input  logic [INDEX_W-1:0]   index,
    output logic                 out_valid,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 transparent,
    input  logic                 wr_en,
    input  logic [BANK_W-1:0]    wr_bank,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [3*COLOR_W-1:0] wr_data,
    input  logic                 frame_start,
    input  logic                 flash_trig,
    output logic                 flash_active
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int DEPTH   = BANKS * ENTRIES;
    localparam int AW      = BANK_W + INDEX_W;
    localparam int RGB_W   = 3 * COLOR_W;

    // Default table is written as 4-bit nibbles; each nibble is replicated
    // from the MSB down so wider channels keep full intensity.
    function automatic logic [RGB_W-1:0] default_rgb(input int idx);
        logic [11:0]      nib;
        logic [RGB_W-1:0] v;
        case (idx)
            0:       nib = 12'hF00;
            1:       nib = 12'hF0B;
            3:       nib = 12'hFFF;
            5:       nib = 12'hFF0;
            6:       nib = 12'hF40;
            8:       nib = 12'h942;
            default: nib = 12'h000;
        endcase
        v = '0;
        for (int c = 0; c < 3; c++) begin
            for (int b = 0; b < COLOR_W; b++) begin
                v[c*COLOR_W + COLOR_W - 1 - b] = nib[c*4 + 3 - (b % 4)];
            end
        end
        return v;
    endfunction

    logic [RGB_W-1:0] palette_q [DEPTH];

    logic               v1_q, v1_d;
    logic [BANK_W-1:0]  bank1_q, bank1_d;
    logic [INDEX_W-1:0] idx1_q, idx1_d;
    logic               out_valid_q, out_valid_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               transp_q, transp_d;

    logic               wr_ok;
    logic [AW-1:0]      wr_addr;
    logic               bank_ok;
    logic [AW-1:0]      rd_addr;
    logic [RGB_W-1:0]   rd_data;
    logic               flash_on;

    // {bank, index} is the flat address because every bank is 2^INDEX_W deep.
    assign wr_ok   = wr_en && (int'(wr_bank) < BANKS);
    assign wr_addr = {wr_bank, wr_index};
    assign bank_ok = int'(bank1_q) < BANKS;
    assign rd_addr = {bank1_q, idx1_q};

    always_comb begin
        rd_data = '0;
        if (bank_ok) begin
            rd_data = palette_q[rd_addr];
        end
    end

    // Reads in stage 2 see the pre-write contents, so a same-edge write is
    // only visible to later lookups.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                palette_q[i] <= default_rgb(i % ENTRIES);
            end
        end else if (wr_ok) begin
            palette_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        v1_d        = pix_valid;
        bank1_d     = bank_sel;
        idx1_d      = index;
        out_valid_d = v1_q;
        rgb_d       = rgb_q;
        transp_d    = transp_q;
        if (v1_q) begin
            transp_d = !bank_ok || (idx1_q == INDEX_W'(TRANSPARENT_IDX));
            if (transp_d) begin
                rgb_d = '0;
            end else if (flash_on) begin
                rgb_d = '1;
            end else begin
                rgb_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q        <= 1'b0;
            bank1_q     <= '0;
            idx1_q      <= '0;
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
            transp_q    <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            bank1_q     <= bank1_d;
            idx1_q      <= idx1_d;
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
            transp_q    <= transp_d;
        end
    end

`ifdef PALETTE_FLASH_EN
    localparam int CW = $clog2(FLASH_LEN + 1);

    logic [CW-1:0] flash_cnt_q, flash_cnt_d;
    logic          flash_active_q, flash_active_d;

    // A trigger always reloads, even when a frame tick lands on the same edge.
    always_comb begin
        flash_cnt_d    = flash_cnt_q;
        flash_active_d = flash_active_q;
        if (flash_trig) begin
            flash_cnt_d    = CW'(FLASH_LEN);
            flash_active_d = 1'b1;
        end else if (flash_active_q && frame_start) begin
            flash_cnt_d = flash_cnt_q - CW'(1);
            if (flash_cnt_q == CW'(1)) begin
                flash_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_cnt_q    <= '0;
            flash_active_q <= 1'b0;
        end else begin
            flash_cnt_q    <= flash_cnt_d;
            flash_active_q <= flash_active_d;
        end
    end

    assign flash_on = flash_active_q;
`else
    logic unused_flash_inputs;
    assign unused_flash_inputs = ^{frame_start, flash_trig};
    assign flash_on = 1'b0;
`endif

    assign flash_active = flash_on;
    assign out_valid    = out_valid_q;
    assign red          = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign green        = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue         = rgb_q[COLOR_W-1 -: COLOR_W];
    assign transparent  = transp_q;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank (BANKS=3 so bank 3 is out of range).
// Flash checks are compiled only when PALETTE_FLASH_EN is defined.
module tb_sprite_palette_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_valid;
    logic [1:0]  bank_sel;
    logic [3:0]  index;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_index;
    logic [11:0] wr_data;
    logic        frame_start;
    logic        flash_trig;
    logic        flash_active;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_palette_bank #(
        .INDEX_W(4), .BANKS(3), .BANK_W(2), .COLOR_W(4),
        .TRANSPARENT_IDX(0), .FLASH_LEN(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .pix_valid(pix_valid), .bank_sel(bank_sel), .index(index),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue),
        .transparent(transparent),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_data(wr_data),
        .frame_start(frame_start), .flash_trig(flash_trig), .flash_active(flash_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rgb();
        return {20'h0, red, green, blue};
    endfunction

    // Request on one edge; out_valid must stay low after it and rise after the next.
    task automatic lookup(input string tag, input logic [1:0] b, input logic [3:0] i,
                          input logic [11:0] exp_rgb, input logic exp_tr);
        pix_valid = 1'b1;
        bank_sel  = b;
        index     = i;
        tick();
        pix_valid = 1'b0;
        check({tag, ".lat"}, {31'h0, out_valid}, 32'h0);
        tick();
        check({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, ".rgb"}, rgb(), {20'h0, exp_rgb});
        check({tag, ".transp"}, {31'h0, transparent}, {31'h0, exp_tr});
    endtask

    initial begin
        reset_n = 1'b0; pix_valid = 1'b0; bank_sel = '0; index = '0;
        wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_data = '0;
        frame_start = 1'b0; flash_trig = 1'b0;
        repeat (3) tick();
        check("rst.valid", {31'h0, out_valid}, 32'h0);
        check("rst.rgb", rgb(), 32'h0);
        check("rst.transp", {31'h0, transparent}, 32'h0);
        check("rst.flash", {31'h0, flash_active}, 32'h0);
        reset_n = 1'b1;
        tick();

        lookup("b0i1", 2'd0, 4'd1, 12'hF0B, 1'b0);
        tick();
        check("idle.valid", {31'h0, out_valid}, 32'h0);
        check("idle.hold", rgb(), 32'hF0B);

        // Back-to-back on bank 2
        pix_valid = 1'b1; bank_sel = 2'd2; index = 4'd0;
        tick();
        index = 4'd3;
        tick();
        check("b2i0.valid", {31'h0, out_valid}, 32'h1);
        check("b2i0.rgb", rgb(), 32'h000);
        check("b2i0.transp", {31'h0, transparent}, 32'h1);
        index = 4'd8;
        tick();
        pix_valid = 1'b0;
        check("b2i3.valid", {31'h0, out_valid}, 32'h1);
        check("b2i3.rgb", rgb(), 32'hFFF);
        check("b2i3.transp", {31'h0, transparent}, 32'h0);
        tick();
        check("b2i8.valid", {31'h0, out_valid}, 32'h1);
        check("b2i8.rgb", rgb(), 32'h942);
        check("b2i8.transp", {31'h0, transparent}, 32'h0);
        tick();
        check("b2.end", {31'h0, out_valid}, 32'h0);

        // Write colliding with stage 2 of a read of the same entry
        pix_valid = 1'b1; bank_sel = 2'd1; index = 4'd5;
        tick();
        pix_valid = 1'b0;
        wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd5; wr_data = 12'h0F0;
        tick();
        wr_en = 1'b0;
        check("coll.valid", {31'h0, out_valid}, 32'h1);
        check("coll.old", rgb(), 32'hFF0);
        lookup("b1i5.new", 2'd1, 4'd5, 12'h0F0, 1'b0);
        lookup("b0i5.same", 2'd0, 4'd5, 12'hFF0, 1'b0);

        // Out-of-range bank read and ignored write
        lookup("b3i1", 2'd3, 4'd1, 12'h000, 1'b1);
        wr_en = 1'b1; wr_bank = 2'd3; wr_index = 4'd3; wr_data = 12'h123;
        tick();
        wr_en = 1'b0;
        lookup("b0i3", 2'd0, 4'd3, 12'hFFF, 1'b0);
        lookup("b1i3", 2'd1, 4'd3, 12'hFFF, 1'b0);
        lookup("b2i3", 2'd2, 4'd3, 12'hFFF, 1'b0);

        // Reset with lookups in flight
        pix_valid = 1'b1; bank_sel = 2'd1; index = 4'd1;
        tick();
        tick();
        check("pre.valid", {31'h0, out_valid}, 32'h1);
        check("pre.rgb", rgb(), 32'hF0B);
        #2 reset_n = 1'b0;
        #1;
        check("arst.valid", {31'h0, out_valid}, 32'h0);
        check("arst.rgb", rgb(), 32'h0);
        check("arst.transp", {31'h0, transparent}, 32'h0);
        tick();
        pix_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        check("post.nopulse1", {31'h0, out_valid}, 32'h0);
        tick();
        check("post.nopulse2", {31'h0, out_valid}, 32'h0);
        lookup("post.b1i5", 2'd1, 4'd5, 12'hFF0, 1'b0);

`ifdef PALETTE_FLASH_EN
        flash_trig = 1'b1;
        tick();
        flash_trig = 1'b0;
        check("fl.on", {31'h0, flash_active}, 32'h1);
        lookup("fl.i1", 2'd0, 4'd1, 12'hFFF, 1'b0);
        lookup("fl.i0", 2'd0, 4'd0, 12'h000, 1'b1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("fl.fs1", {31'h0, flash_active}, 32'h1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("fl.fs2", {31'h0, flash_active}, 32'h0);
        lookup("fl.off", 2'd0, 4'd1, 12'hF0B, 1'b0);
        flash_trig = 1'b1; tick(); flash_trig = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("re.fs1", {31'h0, flash_active}, 32'h1);
        flash_trig = 1'b1; frame_start = 1'b1; tick();
        flash_trig = 1'b0; frame_start = 1'b0;
        check("re.trig", {31'h0, flash_active}, 32'h1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("re.fs2", {31'h0, flash_active}, 32'h1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("re.fs3", {31'h0, flash_active}, 32'h0);
`else
        flash_trig = 1'b1; frame_start = 1'b1;
        tick();
        flash_trig = 1'b0; frame_start = 1'b0;
        check("nofl.active", {31'h0, flash_active}, 32'h0);
        lookup("nofl.i1", 2'd0, 4'd1, 12'hF0B, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Parametrised, registered, runtime-writable sprite colour palette.
- Holds BANKS palettes of 2^INDEX_W entries each. Per-sprite team or variant colours are chosen with bank_sel instead of instantiating one palette module per sprite.
- Sits between the sprite ROM index output and the VGA colour mux.
- Two-cycle pipelined lookup with valid tracking, transparency flag and a host write port.

Parameters:
- INDEX_W, 4, width of the colour index; 2^INDEX_W entries per bank.
- BANKS, 4, number of palette banks (1..16).
- BANK_W, 2, width of the bank_sel and wr_bank ports; must satisfy 2^BANK_W >= BANKS.
- COLOR_W, 4, bits per colour channel.
- TRANSPARENT_IDX, 0, index that is reported as transparent.
- FLASH_LEN, 8, frames a flash lasts (used only with the optional feature).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- pix_valid, input, 1, lookup request this cycle.
- bank_sel, input, BANK_W, bank for the lookup.
- index, input, INDEX_W, colour index for the lookup.
- out_valid, output, 1, red/green/blue/transparent are valid.
- red, output, COLOR_W, red channel.
- green, output, COLOR_W, green channel.
- blue, output, COLOR_W, blue channel.
- transparent, output, 1, looked-up index equals TRANSPARENT_IDX, or the bank is invalid.
- wr_en, input, 1, palette write strobe.
- wr_bank, input, BANK_W, bank to write.
- wr_index, input, INDEX_W, entry to write.
- wr_data, input, 3*COLOR_W, packed {r,g,b} value.
- frame_start, input, 1, one-cycle pulse per video frame.
- flash_trig, input, 1, start a flash.
- flash_active, output, 1, flash in progress.

Behaviour:
- Reset:
  - Asynchronous on reset_n low.
  - out_valid, red, green, blue, transparent and flash_active all go to 0. Pipeline registers clear.
  - Every bank loads the default table, entries 0..8: F00, F0B, 000, FFF, 000, FF0, F40, 000, 942 (hex r,g,b at COLOR_W=4). All remaining entries load 000.
  - For COLOR_W>4, each default nibble is replicated to fill the channel.
- Reset mid-stream: in-flight lookups are discarded with no output pulse. Palette writes made before reset are lost.
- Stage 1 (edge N): registers pix_valid, bank_sel and index.
- Stage 2 (edge N+1): reads the array at the registered bank and index, then registers the colour, transparent flag and out_valid.
- Latency: exactly 2 cycles, request to out_valid.
- Throughput: one lookup per cycle, no stalls.
- When out_valid=0, the colour outputs hold their last value. transparent also holds.
- Bank outside the range (bank_sel >= BANKS): output 000 with transparent=1; out_valid still follows pix_valid.
- Writes:
  - Commit on the clock edge where wr_en=1.
  - Writes to a bank >= BANKS are ignored.
  - A write and a stage-2 read of the same entry on the same edge: the read returns the old value. The new value is visible from the next edge.
- Simultaneous lookups and writes to different entries are independent.

Optional Feature:
- Macro: PALETTE_FLASH_EN.
- With the macro defined:
  - A flash_trig pulse loads a frame counter with FLASH_LEN and sets flash_active=1 on the next edge.
  - Each frame_start while active decrements the counter. flash_active clears on the edge where the counter reaches 0.
  - A flash_trig during an active flash reloads FLASH_LEN (restart).
  - flash_trig and frame_start on the same edge: the reload wins.
  - While flash_active=1, stage 2 outputs all-ones colour for every non-transparent lookup. Transparent lookups output 000.
- Without the macro: frame_start and flash_trig are ignored, flash_active is tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then pix_valid=1, bank 0, index 1 at cycle 0 -> cycle 2: out_valid=1, rgb=F,0,B, transparent=0.
- Back-to-back lookups of indices 0,3,8 on bank 2 -> three consecutive out_valid cycles in order:
  - index 0: rgb 000, transparent=1.
  - index 3: rgb FFF, transparent=0.
  - index 8: rgb 942, transparent=0.
- Write wr_bank=1, wr_index=5, wr_data=0x0F0 on the same edge as stage 2 of a bank 1 index 5 read -> that read returns FF0. The next lookup returns 0F0. Bank 0 index 5 is still FF0.
- bank_sel=3 with BANKS=3 -> rgb 000, transparent=1, out_valid=1. A write to wr_bank=3 leaves all banks unchanged.
- Assert reset_n low while lookups are in flight -> all outputs 0 immediately. The first post-reset lookup of bank 1 index 5 returns the default FF0.
- PALETTE_FLASH_EN defined, FLASH_LEN=2: flash_trig -> flash_active=1. Index 1 lookups return FFF and index 0 lookups return 000 with transparent=1. flash_active clears after the 2nd frame_start. Retrigger after the 1st frame_start -> 2 further frame_starts are needed.
